// File: rtl/regfile_xfer_engine.sv
// Bulk dump/load engine for the register file: walks a contiguous register range
// and bridges it to valid/ready streams while holding the core off via busy.
module regfile_xfer_engine #(
    parameter int AW = 5,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic          cmd_op,
    input  logic [AW-1:0] cmd_first,
    input  logic [AW:0]   cmd_count,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [AW-1:0] rf_raddr,
    input  logic [DW-1:0] rf_rdata,
    output logic [AW-1:0] rf_waddr,
    output logic [DW-1:0] rf_wdata,
    output logic          rf_we,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic [1:0]    dbg_state
);

    // Handshakes: a word moves on a rising edge where valid && ready; a producer
    // holding valid keeps its data stable until ready is seen.
    typedef enum logic [1:0] {IDLE, DUMP, LOAD, FIN} state_t;

    localparam logic [AW:0] MAX_COUNT = (AW + 1)'(2 ** AW);
    localparam logic [AW:0] ONE       = (AW + 1)'(1);

    state_t        state;
    logic [AW-1:0] ptr;
    logic [AW:0]   remaining;
    logic          err_flag;
    logic          cmd_ok;
    logic          capture;

    assign cmd_ok    = (cmd_count != '0) && (cmd_count <= MAX_COUNT);
    assign capture   = (state == DUMP) && (remaining != '0) && (!out_valid || out_ready);

    assign cmd_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign done      = (state == FIN);
    assign err       = (state == FIN) && err_flag;
    assign dbg_state = state;

    // Register file ports are combinational so a LOAD write lands on the handshake edge.
    assign rf_raddr  = (state == DUMP) ? ptr : '0;
    assign in_ready  = (state == LOAD);
    assign rf_waddr  = (state == LOAD) ? ptr : '0;
    assign rf_wdata  = (state == LOAD) ? in_data : '0;
    assign rf_we     = (state == LOAD) && in_valid && (ptr != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= '0;
            remaining <= '0;
            err_flag  <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        ptr       <= cmd_first;
                        remaining <= cmd_count;
                        err_flag  <= !cmd_ok;
                        if (!cmd_ok)
                            state <= FIN;
                        else if (cmd_op)
                            state <= LOAD;
                        else
                            state <= DUMP;
                    end
                end
                DUMP: begin
                    if (capture) begin
                        out_data  <= rf_rdata;
                        out_valid <= 1'b1;
                        ptr       <= ptr + 1'b1;
                        remaining <= remaining - 1'b1;
                    end else if (out_valid && out_ready) begin
                        // Only reachable once every word has been captured.
                        out_valid <= 1'b0;
                        state     <= FIN;
                    end
                end
                LOAD: begin
                    if (in_valid) begin
                        ptr       <= ptr + 1'b1;
                        remaining <= remaining - 1'b1;
                        if (remaining == ONE)
                            state <= FIN;
                    end
                end
                FIN: begin
                    err_flag <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_xfer_engine.sv
// Directed bench for regfile_xfer_engine with a behavioural register file;
// inputs change 1ns after a rising edge, outputs are sampled on the falling edge.
module tb_regfile_xfer_engine;

    localparam int AW = 5;
    localparam int DW = 32;

    logic          clk;
    logic          rst;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_op;
    logic [AW-1:0] cmd_first;
    logic [AW:0]   cmd_count;
    logic          busy;
    logic          done;
    logic          err;
    logic [AW-1:0] rf_raddr;
    logic [DW-1:0] rf_rdata;
    logic [AW-1:0] rf_waddr;
    logic [DW-1:0] rf_wdata;
    logic          rf_we;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [1:0]    dbg_state;

    int n_cmp;
    int n_fail;

    logic [DW-1:0] exp_q[$];

    // register file model
    logic [DW-1:0] rf_mem [32];
    logic          mem_clr;
    logic          pre_we;
    logic [AW-1:0] pre_addr;
    logic [DW-1:0] pre_data;

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 32; i++) rf_mem[i] <= '0;
        end else if (pre_we) begin
            rf_mem[pre_addr] <= pre_data;
        end else if (rf_we) begin
            rf_mem[rf_waddr] <= rf_wdata;
        end
    end

    assign rf_rdata = (rf_raddr == '0) ? '0 : rf_mem[rf_raddr];

    regfile_xfer_engine #(.AW(AW), .DW(DW)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_first(cmd_first), .cmd_count(cmd_count),
        .busy(busy), .done(done), .err(err),
        .rf_raddr(rf_raddr), .rf_rdata(rf_rdata),
        .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .rf_we(rf_we),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .dbg_state(dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // drivers
    task automatic preload(input logic [AW-1:0] addr, input logic [DW-1:0] data);
        pre_we   = 1'b1;
        pre_addr = addr;
        pre_data = data;
        @(posedge clk); #1;
        pre_we   = 1'b0;
    endtask

    // Offer a command while idle; returns at +1ns inside cycle E0+1.
    task automatic issue_cmd(input logic op, input logic [AW-1:0] first, input logic [AW:0] count);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_first = first;
        cmd_count = count;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1;
        n_cmp++; if (busy !== 1'b0)      begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_cmd_ready: got %b want 1", cmd_ready); end
        n_cmp++; if (done !== 1'b0 || err !== 1'b0) begin n_fail++; $display("FAIL reset_done_err: got %b%b want 00", done, err); end
        n_cmp++; if (out_valid !== 1'b0 || out_data !== '0) begin n_fail++; $display("FAIL reset_out: got v=%b d=%h want v=0 d=0", out_valid, out_data); end
        n_cmp++; if (in_ready !== 1'b0 || rf_we !== 1'b0) begin n_fail++; $display("FAIL reset_in: got rdy=%b we=%b want 0 0", in_ready, rf_we); end
        n_cmp++; if (rf_raddr !== '0 || rf_waddr !== '0) begin n_fail++; $display("FAIL reset_addr: got r=%0d w=%0d want 0 0", rf_raddr, rf_waddr); end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_dump();
        int done_cyc;
        int hs;
        logic [DW-1:0] e;
        exp_q = {32'h33, 32'h44, 32'h55, 32'h66};
        out_ready = 1'b1;
        done_cyc = 0;
        hs = 0;
        issue_cmd(1'b0, 5'd3, 6'd4);
        for (int cyc = 1; cyc <= 20 && done_cyc == 0; cyc++) begin
            @(negedge clk);
            if (out_valid && out_ready) begin
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hdead_beef;
                n_cmp++; if (out_data !== e) begin n_fail++; $display("FAIL dump_data: got %h want %h", out_data, e); end
                n_cmp++; if (cyc != hs + 2) begin n_fail++; $display("FAIL dump_beat_cycle: got %0d want %0d", cyc, hs + 2); end
                hs++;
            end
            if (done) begin
                done_cyc = cyc;
                n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL dump_err: got %b want 0", err); end
            end
            @(posedge clk); #1;
        end
        n_cmp++; if (done_cyc != 6) begin n_fail++; $display("FAIL dump_done_cycle: got %0d want 6", done_cyc); end
        n_cmp++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL dump_words_left: got %0d want 0", exp_q.size()); end
        @(negedge clk);
        n_cmp++; if (busy !== 1'b0 || cmd_ready !== 1'b1) begin n_fail++; $display("FAIL dump_busy_after: got busy=%b rdy=%b want 0 1", busy, cmd_ready); end
        @(posedge clk); #1;
    endtask

    task automatic test_dump_stall();
        logic rdy_pat [4];
        logic prev_stall;
        logic [DW-1:0] prev_data;
        logic [DW-1:0] e;
        int done_seen;
        rdy_pat = '{1'b1, 1'b0, 1'b0, 1'b1};
        exp_q = {32'h33, 32'h44, 32'h55, 32'h66};
        prev_stall = 1'b0;
        prev_data = '0;
        done_seen = 0;
        issue_cmd(1'b0, 5'd3, 6'd4);
        for (int cyc = 1; cyc <= 40 && done_seen == 0; cyc++) begin
            out_ready = rdy_pat[(cyc - 1) % 4];
            @(negedge clk);
            if (prev_stall) begin
                n_cmp++; if (out_valid !== 1'b1 || out_data !== prev_data) begin n_fail++; $display("FAIL stall_hold: got v=%b d=%h want v=1 d=%h", out_valid, out_data, prev_data); end
            end
            if (out_valid && out_ready) begin
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hdead_beef;
                n_cmp++; if (out_data !== e) begin n_fail++; $display("FAIL stall_data: got %h want %h", out_data, e); end
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            if (done) done_seen = 1;
            @(posedge clk); #1;
        end
        n_cmp++; if (done_seen != 1) begin n_fail++; $display("FAIL stall_done: got %0d want 1", done_seen); end
        n_cmp++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL stall_words_left: got %0d want 0", exp_q.size()); end
        out_ready = 1'b1;
    endtask

    task automatic test_load_wrap();
        logic [DW-1:0] words [4];
        int done_cyc;
        int k;
        words = '{32'hA, 32'hB, 32'hC, 32'hD};
        done_cyc = 0;
        k = 0;
        issue_cmd(1'b1, 5'd30, 6'd4);
        for (int cyc = 1; cyc <= 20 && done_cyc == 0; cyc++) begin
            in_valid = (k < 4);
            in_data  = (k < 4) ? words[k] : '0;
            @(negedge clk);
            if (cyc == 1) begin
                n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL load_in_ready: got %b want 1", in_ready); end
            end
            if (cyc == 3) begin
                n_cmp++; if (rf_we !== 1'b0 || rf_waddr !== 5'd0) begin n_fail++; $display("FAIL load_x0_beat: got we=%b addr=%0d want we=0 addr=0", rf_we, rf_waddr); end
            end
            if (in_valid && in_ready) k++;
            if (done) done_cyc = cyc;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        n_cmp++; if (done_cyc != 5) begin n_fail++; $display("FAIL load_done_cycle: got %0d want 5", done_cyc); end
        n_cmp++; if (rf_mem[30] !== 32'hA) begin n_fail++; $display("FAIL load_x30: got %h want a", rf_mem[30]); end
        n_cmp++; if (rf_mem[31] !== 32'hB) begin n_fail++; $display("FAIL load_x31: got %h want b", rf_mem[31]); end
        n_cmp++; if (rf_mem[1] !== 32'hD) begin n_fail++; $display("FAIL load_x1: got %h want d", rf_mem[1]); end
        n_cmp++; if (rf_mem[0] !== 32'h0) begin n_fail++; $display("FAIL load_x0: got %h want 0", rf_mem[0]); end
    endtask

    task automatic test_load_gapped();
        logic gap_pat [5];
        logic [AW-1:0] exp_addr;
        int writes;
        int last_hs;
        int done_cyc;
        gap_pat = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        exp_addr = 5'd10;
        writes = 0;
        last_hs = 0;
        done_cyc = 0;
        issue_cmd(1'b1, 5'd10, 6'd3);
        for (int cyc = 1; cyc <= 20 && done_cyc == 0; cyc++) begin
            in_valid = (cyc <= 5) ? gap_pat[cyc - 1] : 1'b0;
            in_data  = 32'h100 + cyc;
            @(negedge clk);
            if (rf_we) begin
                writes++;
                n_cmp++; if (rf_waddr !== exp_addr) begin n_fail++; $display("FAIL gap_addr: got %0d want %0d", rf_waddr, exp_addr); end
                exp_addr = exp_addr + 1'b1;
            end
            if (in_valid && in_ready) last_hs = cyc;
            if (done) done_cyc = cyc;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        n_cmp++; if (writes != 3) begin n_fail++; $display("FAIL gap_writes: got %0d want 3", writes); end
        n_cmp++; if (done_cyc != 6 || last_hs != 5) begin n_fail++; $display("FAIL gap_done_cycle: got done=%0d hs=%0d want 6 5", done_cyc, last_hs); end
        n_cmp++; if (rf_mem[10] !== 32'h101 || rf_mem[11] !== 32'h103 || rf_mem[12] !== 32'h105) begin
            n_fail++; $display("FAIL gap_data: got %h %h %h want 101 103 105", rf_mem[10], rf_mem[11], rf_mem[12]);
        end
    endtask

    task automatic test_error(input logic op, input logic [AW:0] count);
        int activity;
        activity = 0;
        in_valid = 1'b1;
        issue_cmd(op, 5'd7, count);
        for (int cyc = 1; cyc <= 3; cyc++) begin
            @(negedge clk);
            if (rf_we || out_valid || in_ready) activity++;
            if (cyc == 1) begin
                n_cmp++; if (done !== 1'b1 || err !== 1'b1) begin n_fail++; $display("FAIL err_pulse(count=%0d): got done=%b err=%b want 1 1", count, done, err); end
            end
            if (cyc == 2) begin
                n_cmp++; if (busy !== 1'b0 || err !== 1'b0) begin n_fail++; $display("FAIL err_after(count=%0d): got busy=%b err=%b want 0 0", count, busy, err); end
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        n_cmp++; if (activity != 0) begin n_fail++; $display("FAIL err_activity(count=%0d): got %0d want 0", count, activity); end
    endtask

    task automatic test_reset_mid();
        int got55;
        int done_cyc;
        out_ready = 1'b1;
        issue_cmd(1'b0, 5'd3, 6'd5);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        n_cmp++; if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL midrst_outputs: got v=%b busy=%b done=%b want 0 0 0", out_valid, busy, done); end
        n_cmp++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_cmd_ready: got %b want 1", cmd_ready); end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        got55 = 0;
        done_cyc = 0;
        issue_cmd(1'b0, 5'd5, 6'd1);
        for (int cyc = 1; cyc <= 10 && done_cyc == 0; cyc++) begin
            @(negedge clk);
            if (cyc == 1) begin
                n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL midrst_accept: got busy=%b want 1", busy); end
            end
            if (out_valid && out_ready && out_data === 32'h55) got55++;
            if (done) done_cyc = cyc;
            @(posedge clk); #1;
        end
        n_cmp++; if (got55 != 1 || done_cyc != 3) begin n_fail++; $display("FAIL midrst_newcmd: got words=%0d done=%0d want 1 3", got55, done_cyc); end
    endtask

    initial begin
        n_cmp = 0;
        n_fail = 0;
        cmd_valid = 1'b0; cmd_op = 1'b0; cmd_first = '0; cmd_count = '0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        pre_we = 1'b0; pre_addr = '0; pre_data = '0;
        mem_clr = 1'b1;
        rst = 1'b1;
        @(posedge clk); #1;
        mem_clr = 1'b0;
        test_reset();
        preload(5'd3, 32'h33);
        preload(5'd4, 32'h44);
        preload(5'd5, 32'h55);
        preload(5'd6, 32'h66);
        test_dump();
        test_dump_stall();
        test_load_wrap();
        test_load_gapped();
        test_error(1'b0, 6'd0);
        test_error(1'b1, 6'd33);
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_xfer_engine.md
# regfile_xfer_engine

Sequencing initiator that drives the register file's read and write ports to bulk-dump or bulk-load a contiguous range of architectural registers over valid/ready streams. It sits between the debug/test host and the register file and holds the core (via `busy`) while it owns the ports. It is the active master for the register file's passive port protocol. It generates addresses, write enables and data, and turns combinational read data into a flow-controlled stream.

## Interface
Parameters:
- `AW`, default 5: register address width.
- `DW`, default 32: register data width.

Ports:
- `clk`, in, 1: clock.
- `rst`, in, 1: reset; asynchronous, active-high.
- `cmd_valid`, in, 1: command offered.
- `cmd_ready`, out, 1: equals `!busy`.
- `cmd_op`, in, 1: 0 = DUMP (read registers out), 1 = LOAD (write registers in).
- `cmd_first`, in, AW: first register index.
- `cmd_count`, in, AW+1: number of registers, 1..32.
- `busy`, out, 1: engine owns register file ports; core must stall.
- `done`, out, 1: one-cycle pulse at command end.
- `err`, out, 1: one-cycle pulse with `done` for an illegal command.
- `rf_raddr`, out, AW: register file read address.
- `rf_rdata`, in, DW: register file read data, combinational from `rf_raddr`.
- `rf_waddr`, out, AW: write address.
- `rf_wdata`, out, DW: write data.
- `rf_we`, out, 1: write enable.
- `in_valid`, in, 1: LOAD data stream valid.
- `in_ready`, out, 1: LOAD data stream ready.
- `in_data`, in, DW: LOAD data.
- `out_valid`, out, 1: DUMP data stream valid.
- `out_ready`, in, 1: DUMP data stream ready.
- `out_data`, out, DW: DUMP data.

## Operation
- States: IDLE, DUMP, LOAD, FIN.
- IDLE: a command is accepted when `cmd_valid && cmd_ready`. On acceptance, latch the address pointer `ptr = cmd_first` and `remaining = cmd_count`.
- If `cmd_count == 0` or `cmd_count > 32`: go to FIN with the error flag set. No port activity occurs.
- Otherwise, go to DUMP (`cmd_op` = 0) or LOAD (`cmd_op` = 1).
- Address arithmetic: `ptr` increments modulo 2^AW, so 31 wraps to 0. `remaining` decrements per transferred word.
- DUMP:
  - `rf_raddr = ptr`.
  - When `!out_valid || out_ready`: capture `out_data <= rf_rdata`, set `out_valid`, increment `ptr`, decrement `remaining`.
  - After the final capture, no further captures occur.
  - When the last word completes its handshake (`out_valid && out_ready`, nothing remaining), `out_valid` clears and the state goes to FIN.
- LOAD:
  - `in_ready = 1`.
  - `rf_waddr = ptr`, `rf_wdata = in_data`, `rf_we = in_valid && (ptr != 0)`. These are combinational, so the write lands at the handshake edge.
  - A word addressed to x0 is consumed but not written.
  - Each handshake increments `ptr` and decrements `remaining`. The last handshake goes to FIN.
- FIN: `done = 1`, `err` = error flag, then return to IDLE.
- `busy` is 1 in DUMP, LOAD and FIN; `cmd_ready = 0` there. Commands offered while busy are not accepted.
- Outside LOAD: `rf_we = 0` and `in_ready = 0`.
- Outside DUMP: `rf_raddr = 0`.
- `out_data` is held stable while `out_valid && !out_ready`.

## Timing
- Reset values: state IDLE, `busy = 0`, `cmd_ready = 1`, `done = 0`, `err = 0`, `out_valid = 0`, `out_data = 0`, `in_ready = 0`, `rf_we = 0`, all addresses 0.
- Reset mid-command aborts immediately. A partially dumped word is dropped. LOAD writes already performed remain in the register file.
- Command accepted at edge E0: state is DUMP/LOAD in cycle E0+1.
- DUMP:
  - The first `out_valid` is high in cycle E0+2.
  - With `out_ready` held at 1, throughput is 1 word per cycle.
  - N words complete their handshakes in cycles E0+2..E0+N+1.
  - `done` is high in cycle E0+N+2.
- LOAD:
  - `in_ready` is high from cycle E0+1.
  - With `in_valid` held at 1, words are written in cycles E0+1..E0+N.
  - `done` is high in cycle E0+N+1.
- Error command: `done` and `err` are high in cycle E0+1.
- `busy` falls in the cycle after `done`. The next command can be accepted in that cycle.

## Test plan
- Preload x3..x6 with 0x33, 0x44, 0x55, 0x66. Issue DUMP, first = 3, count = 4, with `out_ready` = 1. Required: `out_data` sequence 0x33, 0x44, 0x55, 0x66 on consecutive cycles; `done` 6 cycles after acceptance; `err` = 0.
- Repeat the DUMP with `out_ready` toggling 1, 0, 0, 1, … Required: each word is held stable while stalled; no word is lost or duplicated; order is unchanged.
- LOAD, first = 30, count = 4, data 0xA, 0xB, 0xC, 0xD. Required: x30 = 0xA, x31 = 0xB, x1 = 0xD; `rf_we` = 0 on the x0 beat; x0 still reads 0.
- LOAD with `in_valid` gapped (1, 0, 1, 0, 1) for count = 3. Required: exactly 3 writes, to consecutive addresses; `done` one cycle after the third handshake.
- Command with count = 0, then count = 33. Required: each gives `done` = `err` = 1 one cycle after acceptance; no `rf_we`; no `out_valid`.
- Assert `rst` during the second beat of a 5-word DUMP. Required: `out_valid`, `busy`, `done` = 0 immediately; `cmd_ready` = 1; a new command is accepted after `rst` drops.
